// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, widths and issue FSM states for the ALU issue stage
package alu_pkg;

    localparam int OP_W   = 2;
    localparam int DATA_W = 32;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_MUL = 2'b10;

    // IDLE: queue empty; ISSUE: may pop when gap is zero; HOLD: waiting out the throttle gap
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } issue_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, head-visible read data, no full-write bypass
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 66
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses the write even when the head is popped in the same cycle.
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage array; contents are don't-care after reset because the pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks net push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - throttled issue stage feeding the ALU, with DVFS activity counters
module alu_issue_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W,
    parameter int CNT_W  = 16,
    parameter int GAP_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          in_op,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    input  logic [GAP_W-1:0]         throttle,
    input  logic                     cnt_clr,
    output logic                     alu_en,
    output logic [OP_W-1:0]          alu_op,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         issue_cnt,
    output logic [CNT_W-1:0]         busy_cnt
);

    import alu_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = OP_W + 2 * DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    issue_state_e      state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              alu_en_q;
    logic [OP_W-1:0]   alu_op_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic [CNT_W-1:0]  busy_cnt_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [EW-1:0]     head;
    logic              push;
    logic              issue;
    logic [CW-1:0]     count_nxt;

    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign issue     = (state_q == ST_ISSUE) && !fifo_empty && (gap_q == '0);
    assign count_nxt = fifo_count + CW'(push) - CW'(issue);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (issue),
        .wdata_i ({in_op, in_a, in_b}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Next state: HOLD hands back to ISSUE on the edge where the gap hits zero so spacing is throttle+1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (push) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue && (throttle != '0)) begin
                    state_d = ST_HOLD;
                end else if (count_nxt == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = (count_nxt != '0) ? ST_ISSUE : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gap counter: reload from throttle at each issue, otherwise count down to zero.
    always_comb begin
        gap_d = gap_q;
        if (issue) begin
            gap_d = throttle;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end
    end

    // State and gap registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // ALU drive registers: one-cycle enable strobe, operands hold their last issued value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_en_q <= 1'b0;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
        end else begin
            alu_en_q <= issue;
            if (issue) begin
                {alu_op_q, alu_a_q, alu_b_q} <= head;
            end
        end
    end

    // Workload monitor counters: saturating, with clear taking priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            busy_cnt_q  <= '0;
        end else if (cnt_clr) begin
            issue_cnt_q <= '0;
            busy_cnt_q  <= '0;
        end else begin
            if (issue && (issue_cnt_q != CNT_MAX)) begin
                issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            end
            if ((fifo_count != '0) && (busy_cnt_q != CNT_MAX)) begin
                busy_cnt_q <= busy_cnt_q + CNT_W'(1);
            end
        end
    end

    assign alu_en    = alu_en_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign occupancy = fifo_count;
    assign issue_cnt = issue_cnt_q;
    assign busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - randomized self-checking bench for alu_issue_queue
module tb_alu_issue_queue;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int OP_W   = 2;
    localparam int CNT_W  = 8;
    localparam int GAP_W  = 4;
    localparam int EW     = OP_W + 2 * DATA_W;
    localparam int OW     = $clog2(DEPTH) + 1;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [GAP_W-1:0]  throttle;
    logic              cnt_clr;
    logic              alu_en;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OW-1:0]     occupancy;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  busy_cnt;

    alu_issue_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .CNT_W  (CNT_W),
        .GAP_W  (GAP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .throttle  (throttle),
        .cnt_clr   (cnt_clr),
        .alu_en    (alu_en),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .occupancy (occupancy),
        .issue_cnt (issue_cnt),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of pending ops plus the earliest cycle the next issue may happen.
    logic [EW-1:0] mq[$];
    int            cyc = 0;
    int            m_next = 0;
    logic          m_en = 1'b0;
    logic [EW-1:0] m_out = '0;
    int            m_issue = 0;
    int            m_busy = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_next  = 0;
        m_en    = 1'b0;
        m_out   = '0;
        m_issue = 0;
        m_busy  = 0;
    endtask

    // One clock: drive at negedge, predict, sample 1ns after the rising edge.
    task automatic step(input logic v, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, input logic [GAP_W-1:0] thr, input logic clr);
        logic do_push;
        logic do_iss;
        logic busy_pre;
        @(negedge clk);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        throttle = thr;
        cnt_clr  = clr;
        #1;
        check_eq("in_ready", in_ready, mq.size() != DEPTH);
        do_push  = v && (mq.size() < DEPTH);
        do_iss   = (mq.size() > 0) && (cyc >= m_next);
        busy_pre = (mq.size() != 0);
        @(posedge clk);
        #1;
        if (clr) begin
            m_issue = 0;
            m_busy  = 0;
        end else begin
            if (do_iss && m_issue < CMAX) m_issue++;
            if (busy_pre && m_busy < CMAX) m_busy++;
        end
        if (do_iss) begin
            m_out  = mq.pop_front();
            m_en   = 1'b1;
            m_next = cyc + int'(thr) + 1;
        end else begin
            m_en = 1'b0;
        end
        if (do_push) mq.push_back({op, a, b});
        cyc++;
        check_eq("alu_en", alu_en, m_en);
        check_eq("alu_data", {alu_op, alu_a, alu_b}, m_out);
        check_eq("occupancy", occupancy, mq.size());
        check_eq("issue_cnt", issue_cnt, m_issue);
        check_eq("busy_cnt", busy_cnt, m_busy);
    endtask

    task automatic idle(input logic [GAP_W-1:0] thr);
        step(1'b0, '0, '0, '0, thr, 1'b0);
    endtask

    // Let the model's throttle gap expire so the next phase starts from a clean issue slot.
    task automatic idle_until_ready();
        int guard = 0;
        while ((cyc < m_next || mq.size() != 0) && guard < 400) begin
            idle(4'd0);
            guard++;
        end
        check_eq("settle_bound", guard < 400, 1'b1);
    endtask

    initial begin
        int run;
        int max_run;
        int last;
        int guard;
        bit found;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = '0;
        in_a     = '0;
        in_b     = '0;
        throttle = '0;
        cnt_clr  = 1'b0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_alu_en", alu_en, 1'b0);
        check_eq("rst_alu_data", {alu_op, alu_a, alu_b}, '0);
        check_eq("rst_occupancy", occupancy, '0);
        check_eq("rst_issue_cnt", issue_cnt, '0);
        check_eq("rst_busy_cnt", busy_cnt, '0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single op, throttle 0: issue one cycle after acceptance
        step(1'b1, 2'b01, 32'h0000_000A, 32'h0000_0003, 4'd0, 1'b0);
        check_eq("t1_en_not_comb", alu_en, 1'b0);
        idle(4'd0);
        check_eq("t1_en", alu_en, 1'b1);
        check_eq("t1_op", alu_op, 2'b01);
        check_eq("t1_a", alu_a, 32'hA);
        check_eq("t1_b", alu_b, 32'h3);
        check_eq("t1_issue_cnt", issue_cnt, 1);
        check_eq("t1_occ", occupancy, 0);
        idle(4'd0);
        check_eq("t1_en_one_cycle", alu_en, 1'b0);
        check_eq("t1_op_hold", alu_op, 2'b01);

        // Fill to full under throttle 15, then drain with 16-cycle spacing
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 2'($urandom), 32'h100 + i, $urandom, 4'd15, 1'b0);
            if (i >= 8) begin
                check_eq("t2_full_occ", occupancy, DEPTH);
                check_eq("t2_full_ready", in_ready, 1'b0);
            end
        end
        last = -1;
        guard = 0;
        while (mq.size() != 0 && guard < 300) begin
            idle(4'd15);
            if (alu_en) begin
                if (last >= 0) check_eq("t2_spacing", cyc - last, 16);
                last = cyc;
            end
            guard++;
        end
        check_eq("t2_drain_bound", guard < 300, 1'b1);
        idle_until_ready();

        // Four queued behind a long gap, then released with throttle 0
        run = 0;
        max_run = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'(i), 32'h200 + i, 32'h300 + i, 4'd15, 1'b0);
            run = alu_en ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        for (int i = 0; i < 30; i++) begin
            idle(4'd0);
            run = alu_en ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        check_eq("t3_burst_len", max_run, 4);
        idle_until_ready();

        // Sustained push+pop at occupancy 3 across pointer wrap
        for (int i = 0; i < 4; i++) step(1'b1, 2'b10, 32'h400 + i, 32'h0, 4'd15, 1'b0);
        guard = 0;
        while (cyc < m_next && guard < 40) begin
            idle(4'd0);
            guard++;
        end
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 2'(i), 32'h500 + i, ~(32'h500 + i), 4'd0, 1'b0);
            check_eq("t4_occ3", occupancy, 3);
            check_eq("t4_en", alu_en, 1'b1);
        end
        idle_until_ready();

        // Counter saturation, then clear on an issue cycle
        for (int i = 0; i < 270; i++) step(1'b1, 2'($urandom), $urandom, $urandom, 4'd0, 1'b0);
        check_eq("t5_issue_sat", issue_cnt, CMAX);
        step(1'b1, 2'b00, 32'h1, 32'h2, 4'd0, 1'b0);
        check_eq("t5_issue_hold", issue_cnt, CMAX);
        step(1'b1, 2'b00, 32'h3, 32'h4, 4'd0, 1'b1);
        check_eq("t5_clr_en", alu_en, 1'b1);
        check_eq("t5_clr_issue", issue_cnt, 0);
        check_eq("t5_clr_busy", busy_cnt, 0);
        idle_until_ready();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [GAP_W-1:0] thr;
            thr = ($urandom_range(0, 9) == 0) ? 4'(15) : 4'($urandom_range(0, 2));
            step($urandom_range(0, 99) < 60, 2'($urandom), $urandom, $urandom, thr,
                 $urandom_range(0, 199) == 0);
        end
        idle_until_ready();

        // Asynchronous reset while issuing into HOLD with five ops queued
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(i < 8, 2'b11, 32'h600 + i, 32'h0, 4'd3, 1'b0);
            if (m_en && mq.size() == 5) found = 1'b1;
        end
        check_eq("t6_setup", found, 1'b1);
        check_eq("t6_pre_en", alu_en, 1'b1);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_en", alu_en, 1'b0);
        check_eq("t6_occ", occupancy, 0);
        check_eq("t6_ready", in_ready, 1'b1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            idle(4'd0);
            check_eq("t6_no_issue", alu_en, 1'b0);
        end
        check_eq("t6_issue_cnt", issue_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
